// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: dual-write / dual-read register file with a per-register
// pending (scoreboard) bit and a registered count of pending registers.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding
// of data and busy status; without it reads see only previously stored state.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic [ADDR_WIDTH-1:0] Read1,
    input  logic [ADDR_WIDTH-1:0] Read2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  Busy1,
    output logic                  Busy2,
    input  logic [ADDR_WIDTH-1:0] WriteReg1,
    input  logic [ADDR_WIDTH-1:0] WriteReg2,
    input  logic [DATA_WIDTH-1:0] WriteData1,
    input  logic [DATA_WIDTH-1:0] WriteData2,
    input  logic                  RegWrite1,
    input  logic                  RegWrite2,
    input  logic [ADDR_WIDTH-1:0] IssueReg,
    input  logic                  Issue,
    output logic [ADDR_WIDTH:0]   PendingCount
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int NRD   = 2;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic [CW-1:0]         count_q, count_d;

    logic we1_eff, we2_eff, iss_eff;
    logic inc, dec1, dec2;

    logic [NRD-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NRD-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NRD-1:0]                 rd_busy;

    // Register 0 is a constant sink when ZERO_REG is set.
    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Qualify write and issue enables, dropping any aimed at a hardwired zero register.
    always_comb begin
        we1_eff = RegWrite1 && !is_zero(WriteReg1);
        we2_eff = RegWrite2 && !is_zero(WriteReg2);
        iss_eff = Issue     && !is_zero(IssueReg);
    end

    // Next register/pending state: port 2 write lands after port 1, issue sets last.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (we1_eff) begin
            regs_d[WriteReg1] = WriteData1;
            pend_d[WriteReg1] = 1'b0;
        end
        if (we2_eff) begin
            regs_d[WriteReg2] = WriteData2;
            pend_d[WriteReg2] = 1'b0;
        end
        if (iss_eff) begin
            pend_d[IssueReg] = 1'b1;
        end
    end

    // Netted count delta: a clear only counts if the bit was set and survives
    // the same-cycle issue; a duplicate clear of one register counts once.
    always_comb begin
        inc  = iss_eff && !pend_q[IssueReg];
        dec1 = we1_eff && pend_q[WriteReg1] &&
               !(iss_eff && (IssueReg == WriteReg1));
        dec2 = we2_eff && pend_q[WriteReg2] &&
               !(iss_eff && (IssueReg == WriteReg2)) &&
               !(we1_eff && (WriteReg1 == WriteReg2));
        count_d = count_q + CW'(inc) - CW'(dec1) - CW'(dec2);
    end

    // State registers with synchronous clear overriding all same-cycle updates.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    assign rd_addr = {Read2, Read1};

    // Combinational read ports: stored state, optional forwarding, zero register last.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = pend_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (!Clear) begin
                if (we2_eff && (WriteReg2 == rd_addr[p])) begin
                    rd_data[p] = WriteData2;
                end else if (we1_eff && (WriteReg1 == rd_addr[p])) begin
                    rd_data[p] = WriteData1;
                end
                if (((we1_eff && (WriteReg1 == rd_addr[p])) ||
                     (we2_eff && (WriteReg2 == rd_addr[p]))) &&
                    !(iss_eff && (IssueReg == rd_addr[p]))) begin
                    rd_busy[p] = 1'b0;
                end
            end
`endif
            if (is_zero(rd_addr[p])) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign ReadData1    = rd_data[0];
    assign ReadData2    = rd_data[1];
    assign Busy1        = rd_busy[0];
    assign Busy2        = rd_busy[1];
    assign PendingCount = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus randomized traffic checked
// against an array-based model of the register file and its pending set.
module tb_regfile_scoreboard;

    logic        clk;
    logic        clr;
    logic [4:0]  r1, r2, w1, w2, ir;
    logic [31:0] wd1, wd2;
    logic        we1, we2, iss;
    logic [31:0] rd1, rd2;
    logic        b1, b2;
    logic [5:0]  pc;

    int checks;
    int failures;

    logic [31:0] mregs [32];
    bit          mpend [32];

    regfile_scoreboard dut (
        .Clock(clk), .Clear(clr),
        .Read1(r1), .Read2(r2),
        .ReadData1(rd1), .ReadData2(rd2),
        .Busy1(b1), .Busy2(b2),
        .WriteReg1(w1), .WriteReg2(w2),
        .WriteData1(wd1), .WriteData2(wd2),
        .RegWrite1(we1), .RegWrite2(we2),
        .IssueReg(ir), .Issue(iss),
        .PendingCount(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += mpend[i] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        logic [31:0] v;
        v = mregs[a];
`ifdef REGFILE_BYPASS_EN
        if (!clr && we2 && w2 == a) v = wd2;
        else if (!clr && we1 && w1 == a) v = wd1;
`endif
        if (a == 5'd0) v = '0;
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        logic v;
        v = mpend[a];
`ifdef REGFILE_BYPASS_EN
        if (!clr && ((we1 && w1 == a) || (we2 && w2 == a)) && !(iss && ir == a)) v = 1'b0;
`endif
        if (a == 5'd0) v = 1'b0;
        return v;
    endfunction

    // Apply the architectural effect of the current inputs to the model.
    task automatic model_update();
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] = '0;
                mpend[i] = 1'b0;
            end
        end else begin
            if (we1 && w1 != 5'd0) begin mregs[w1] = wd1; mpend[w1] = 1'b0; end
            if (we2 && w2 != 5'd0) begin mregs[w2] = wd2; mpend[w2] = 1'b0; end
            if (iss && ir != 5'd0) mpend[ir] = 1'b1;
        end
    endtask

    task automatic idle();
        clr = 1'b0; we1 = 1'b0; we2 = 1'b0; iss = 1'b0;
    endtask

    // Advance one clock, keeping the model in step; returns 1 time unit after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        idle(); clr = 1'b1; step(); idle();
    endtask

    task automatic test_reset();
        clr = 1'b1; we1 = 1'b1; w1 = 5'd3; wd1 = 32'h1111;
        we2 = 1'b1; w2 = 5'd4; wd2 = 32'h2222; iss = 1'b1; ir = 5'd6;
        step();
        idle();
        checks++;
        if (pc !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", pc); end
        for (int a = 0; a < 32; a++) begin
            r1 = 5'(a); r2 = 5'(31 - a); #1;
            checks++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                failures++; $display("FAIL reset_data a=%0d got=%h/%h want=0", a, rd1, rd2);
            end
            checks++;
            if (b1 !== 1'b0 || b2 !== 1'b0) begin
                failures++; $display("FAIL reset_busy a=%0d got=%b/%b want=0", a, b1, b2);
            end
        end
    endtask

    task automatic test_dual_write();
        do_clear();
        we1 = 1'b1; w1 = 5'd5; wd1 = 32'hDEADBEEF;
        we2 = 1'b1; w2 = 5'd5; wd2 = 32'h12345678;
        step(); idle();
        r1 = 5'd5; #1;
        checks++;
        if (rd1 !== 32'h12345678) begin failures++; $display("FAIL dual_write got=%h want=12345678", rd1); end
    endtask

    task automatic test_issue_sequence();
        do_clear();
        iss = 1'b1; ir = 5'd7; step(); idle();
        r1 = 5'd7; #1;
        checks++;
        if (pc !== 6'd1 || b1 !== 1'b1) begin failures++; $display("FAIL issue_r7 got=%0d/%b want=1/1", pc, b1); end
        iss = 1'b1; ir = 5'd9; step(); idle();
        checks++;
        if (pc !== 6'd2) begin failures++; $display("FAIL issue_r9 got=%0d want=2", pc); end
        we1 = 1'b1; w1 = 5'd7; wd1 = 32'h1; step(); idle();
        r1 = 5'd7; r2 = 5'd9; #1;
        checks++;
        if (pc !== 6'd1 || b1 !== 1'b0 || b2 !== 1'b1) begin
            failures++; $display("FAIL write_r7 got=%0d/%b/%b want=1/0/1", pc, b1, b2);
        end
        // Write to a non-pending register leaves the count alone.
        we2 = 1'b1; w2 = 5'd12; wd2 = 32'h5; step(); idle();
        checks++;
        if (pc !== 6'd1) begin failures++; $display("FAIL write_nonpending got=%0d want=1", pc); end
        // Re-issue of a pending register leaves the count alone.
        iss = 1'b1; ir = 5'd9; step(); idle();
        checks++;
        if (pc !== 6'd1) begin failures++; $display("FAIL reissue got=%0d want=1", pc); end
    endtask

    task automatic test_issue_write_same();
        do_clear();
        iss = 1'b1; ir = 5'd3; we1 = 1'b1; w1 = 5'd3; wd1 = 32'hAA;
        step(); idle();
        r1 = 5'd3; #1;
        checks++;
        if (rd1 !== 32'hAA || b1 !== 1'b1 || pc !== 6'd1) begin
            failures++; $display("FAIL issue_write_same got=%h/%b/%0d want=aa/1/1", rd1, b1, pc);
        end
        // Pending + issue + write on the same register: count stays.
        iss = 1'b1; ir = 5'd3; we2 = 1'b1; w2 = 5'd3; wd2 = 32'hBB;
        step(); idle();
        #1;
        checks++;
        if (rd1 !== 32'hBB || b1 !== 1'b1 || pc !== 6'd1) begin
            failures++; $display("FAIL reissue_write got=%h/%b/%0d want=bb/1/1", rd1, b1, pc);
        end
    endtask

    task automatic test_bypass();
        do_clear();
        we1 = 1'b1; w1 = 5'd4; wd1 = 32'h11; step(); idle();
        we1 = 1'b1; w1 = 5'd4; wd1 = 32'h55; r2 = 5'd4; #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (rd2 !== 32'h55) begin failures++; $display("FAIL bypass got=%h want=55", rd2); end
`else
        if (rd2 !== 32'h11) begin failures++; $display("FAIL no_bypass got=%h want=11", rd2); end
`endif
        step(); idle(); #1;
        checks++;
        if (rd2 !== 32'h55) begin failures++; $display("FAIL bypass_after got=%h want=55", rd2); end
    endtask

    task automatic test_zero_reg();
        do_clear();
        iss = 1'b1; ir = 5'd0; we1 = 1'b1; w1 = 5'd0; wd1 = 32'hFF;
        step(); idle();
        r1 = 5'd0; #1;
        checks++;
        if (rd1 !== 32'd0 || b1 !== 1'b0 || pc !== 6'd0) begin
            failures++; $display("FAIL zero_reg got=%h/%b/%0d want=0/0/0", rd1, b1, pc);
        end
        for (int i = 0; i < 3; i++) begin
            iss = 1'b1; ir = 5'(10 + i); step();
        end
        idle();
        checks++;
        if (pc !== 6'd3) begin failures++; $display("FAIL three_pending got=%0d want=3", pc); end
        clr = 1'b1; we1 = 1'b1; w1 = 5'd10; wd1 = 32'h77; iss = 1'b1; ir = 5'd20;
        step(); idle();
        r1 = 5'd10; r2 = 5'd20; #1;
        checks++;
        if (pc !== 6'd0 || b1 !== 1'b0 || b2 !== 1'b0 || rd1 !== 32'd0) begin
            failures++; $display("FAIL clear_pending got=%0d/%b/%b/%h want=0/0/0/0", pc, b1, b2, rd1);
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int n = 0; n < 600; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 39) == 0);
            we1 = $urandom_range(0, 1) == 1;
            we2 = $urandom_range(0, 2) == 0;
            iss = $urandom_range(0, 1) == 1;
            w1  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            w2  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            ir  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            r1  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            r2  = 5'($urandom);
            wd1 = $urandom;
            wd2 = $urandom;
            #1;
            checks++;
            if (rd1 !== exp_data(r1) || rd2 !== exp_data(r2)) begin
                failures++;
                $display("FAIL rand_data n=%0d got=%h/%h want=%h/%h", n, rd1, rd2, exp_data(r1), exp_data(r2));
            end
            checks++;
            if (b1 !== exp_busy(r1) || b2 !== exp_busy(r2)) begin
                failures++;
                $display("FAIL rand_busy n=%0d got=%b/%b want=%b/%b", n, b1, b2, exp_busy(r1), exp_busy(r2));
            end
            step();
            checks++;
            if (int'(pc) != model_count()) begin
                failures++; $display("FAIL rand_count n=%0d got=%0d want=%0d", n, pc, model_count());
            end
        end
        idle();
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 32; i++) begin mregs[i] = '0; mpend[i] = 1'b0; end
        r1 = '0; r2 = '0; w1 = '0; w2 = '0; ir = '0; wd1 = '0; wd2 = '0;
        idle();
        @(negedge clk);
        test_reset();
        test_dual_write();
        test_issue_sequence();
        test_issue_write_same();
        test_bypass();
        test_zero_reg();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, giving a depth of 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter ZERO_REG, default 1; when set to 1, register 0 is hardwired to zero.
REQ-004 SHALL have port Clock  input  1  as the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port Clear  input  1  as a synchronous, active-high reset.
REQ-006 SHALL have ports Read1, Read2  input  ADDR_WIDTH  as the read addresses.
REQ-007 SHALL have ports ReadData1, ReadData2  output  DATA_WIDTH  as the read data.
REQ-008 SHALL have ports Busy1, Busy2  output  1  giving the pending status of Read1 and Read2.
REQ-009 SHALL have ports WriteReg1, WriteReg2  input  ADDR_WIDTH  as the write addresses.
REQ-010 SHALL have ports WriteData1, WriteData2  input  DATA_WIDTH  as the write data.
REQ-011 SHALL have ports RegWrite1, RegWrite2  input  1  as the write enables.
REQ-012 SHALL have port IssueReg  input  ADDR_WIDTH  as the destination register of a newly issued instruction.
REQ-013 SHALL have port Issue  input  1  to mark IssueReg pending.
REQ-014 SHALL have port PendingCount  output  ADDR_WIDTH+1  giving the number of pending registers.

Function
REQ-015 Reads SHALL be combinational: ReadDataN = register[ReadN].
REQ-016 With ZERO_REG=1, an address of 0 SHALL read 0 and never report busy; writes and issues to register 0 SHALL be ignored.
REQ-017 A write SHALL update the register at the Clock edge when its RegWrite is high and Clear is low.
REQ-018 When both ports write the same register in one cycle, port 2 SHALL win.
REQ-019 Each register SHALL have a pending bit: Issue sets the bit for IssueReg; any enabled write to a register clears its bit.
REQ-020 When Issue and a write target the same register in one cycle, the pending bit SHALL end up set (the new producer wins); the data write still takes effect.
REQ-021 BusyN SHALL equal the pending bit of ReadN.
REQ-022 PendingCount SHALL be a registered counter equal to the population of pending bits after each edge.
REQ-023 PendingCount SHALL change by -2..+1 per cycle, with simultaneous events netted and duplicate clears of one register counted once.
REQ-024 Writing a register that is not pending SHALL leave PendingCount unchanged.
REQ-025 Issuing a register that is already pending SHALL leave PendingCount unchanged, unless a write in the same cycle clears that register, in which case REQ-020 applies and the count is unchanged.
REQ-026 PendingCount SHALL never wrap; its maximum is 2**ADDR_WIDTH-ZERO_REG.

Reset
REQ-027 When Clear is high at a Clock edge, all registers, all pending bits and PendingCount SHALL become 0.
REQ-028 Clear SHALL override same-cycle writes and issues.
REQ-029 One cycle after Clear is released, ReadData1/2 SHALL read 0 and Busy1/2 SHALL be 0.
REQ-030 Clear asserted mid-operation SHALL discard all pending state without any partial update.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-032 With REGFILE_BYPASS_EN defined:
- if ReadN matches an enabled write address in the same cycle, ReadDataN SHALL return that WriteData (port 2 priority), except for register 0 when ZERO_REG=1;
- BusyN SHALL read 0 for a register being written that cycle, unless Issue targets the same register.
REQ-033 Without REGFILE_BYPASS_EN, ReadDataN and BusyN SHALL reflect only state stored at the previous edge.

Verification
REQ-034 Clear for 1 cycle, then read registers 0..31 -> all ReadData 0, Busy 0, PendingCount 0.
REQ-035 Write port1 r5=0xDEADBEEF and port2 r5=0x12345678 in the same cycle -> next cycle, Read1=5 returns 0x12345678.
REQ-036 Issue r7, then r9, then write r7=0x1 -> PendingCount goes 1, 2, 1; Busy for r7 goes 1 then 0, and Busy for r9 stays 1.
REQ-037 In one cycle, Issue r3 and write r3=0xAA -> r3 reads 0xAA, Busy for r3 is 1, PendingCount +1.
REQ-038 With the macro defined, write r4=0x55 while Read2=4 in the same cycle -> ReadData2=0x55 combinationally; without the macro -> old r4 value.
REQ-039 Issue r0 and write r0=0xFF (ZERO_REG=1) -> r0 reads 0, Busy 0, PendingCount unchanged; then Clear with 3 registers pending -> PendingCount 0 next cycle.
